// File: rtl/imem_program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader:
// FSM state encoding and frame/word geometry.
package imem_program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam int FRAME_LEN_BYTES = 2;
    localparam int BYTES_PER_WORD  = 4;

endpackage

// File: rtl/imem_program_loader_word_assembler.sv
// Collects payload bytes little-endian (first byte lands in bits [7:0]) and
// presents the finished 32-bit word with a one-cycle word_valid.
module imem_program_loader_word_assembler
    import imem_program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  byte_idx;
    logic [23:0] shift;

    assign last_byte = (byte_idx == LAST_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx   <= '0;
            shift      <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_idx <= '0;
            end else if (byte_valid) begin
                if (last_byte) begin
                    word       <= {byte_data, shift};
                    word_valid <= 1'b1;
                    byte_idx   <= '0;
                end else begin
                    shift    <= {byte_data, shift[23:8]};
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_program_loader.sv
// Loads a framed, XOR-checksummed byte stream into instruction memory and
// holds the core in reset until a complete verified image is present.
module imem_program_loader
    import imem_program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] IDLE_RELOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

    state_t        state;
    logic [7:0]    len_lo;
    logic [15:0]   len_q;
    logic [7:0]    chk;
    logic [TW-1:0] idle_cnt;

    logic accept;
    logic start_load;
    logic last_byte;
    logic [15:0] len_now;

    assign accept     = rx_valid && rx_ready;
    assign start_load = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
    assign len_now    = {rx_data, len_lo};

    imem_program_loader_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_load),
        .byte_valid (accept && (state == ST_DATA)),
        .byte_data  (rx_data),
        .last_byte  (last_byte),
        .word_valid (imem_we),
        .word       (imem_wdata)
    );

    // State table:
    //   IDLE    after reset, waiting for start
    //   LEN_LO  expecting low byte of word count
    //   LEN_HI  expecting high byte of word count
    //   DATA    payload bytes, one write per 4 bytes
    //   CHECK   expecting checksum byte
    //   DONE    image verified, core released
    //   ERROR   frame rejected, core held in reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            rx_ready     <= 1'b0;
            imem_addr    <= '0;
            core_reset   <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            len_lo       <= '0;
            len_q        <= '0;
            chk          <= '0;
            idle_cnt     <= IDLE_RELOAD;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state        <= ST_LEN_LO;
                        rx_ready     <= 1'b1;
                        busy         <= 1'b1;
                        core_reset   <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        imem_addr    <= '0;
                        chk          <= '0;
                        idle_cnt     <= IDLE_RELOAD;
                    end
                end
                default: begin
                    if (accept) begin
                        idle_cnt <= IDLE_RELOAD;
                        case (state)
                            ST_LEN_LO: begin
                                len_lo <= rx_data;
                                chk    <= chk ^ rx_data;
                                state  <= ST_LEN_HI;
                            end
                            ST_LEN_HI: begin
                                len_q <= len_now;
                                chk   <= chk ^ rx_data;
                                if ({1'b0, len_now} > MAX_WORDS) begin
                                    state    <= ST_ERROR;
                                    error    <= 1'b1;
                                    rx_ready <= 1'b0;
                                    busy     <= 1'b0;
                                end else if (len_now == 16'd0) begin
                                    state <= ST_CHECK;
                                end else begin
                                    state <= ST_DATA;
                                end
                            end
                            ST_DATA: begin
                                chk <= chk ^ rx_data;
                                if (last_byte) begin
                                    // Address is latched alongside the assembler's write strobe.
                                    imem_addr    <= words_loaded[ADDR_WIDTH-1:0];
                                    words_loaded <= words_loaded + 1'b1;
                                    if (16'(words_loaded) + 16'd1 == len_q)
                                        state <= ST_CHECK;
                                end
                            end
                            ST_CHECK: begin
                                rx_ready <= 1'b0;
                                busy     <= 1'b0;
                                if (rx_data == chk) begin
                                    state      <= ST_DONE;
                                    done       <= 1'b1;
                                    core_reset <= 1'b0;
                                end else begin
                                    state <= ST_ERROR;
                                    error <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end else if (idle_cnt == '0) begin
                        state    <= ST_ERROR;
                        error    <= 1'b1;
                        rx_ready <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: table of frames plus
// hand-written corner sequences, with a write scoreboard.
module tb_imem_program_loader;

    localparam int AW = 8;
    localparam int TO = 50;

    logic          clk;
    logic          reset;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_reset;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    imem_program_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset   (core_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [7:0]  flip;
        logic        exp_done;
    } vec_t;

    wr_t         sb[$];
    logic [31:0] payload[256];
    vec_t        vecs[5];
    int          total = 0;
    int          bad = 0;
    int          nwrites = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Every write strobe must match the next expected write; a strobe held
    // for two cycles shows up as an unexpected write.
    always @(negedge clk) begin
        if (reset && imem_we) begin
            nwrites++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0d data %h want none", imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                expect_eq("wr_addr", 32'(imem_addr), 32'(e.addr));
                expect_eq("wr_data", imem_wdata, e.data);
            end
        end
    end

    // Called and returns at 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rx_ready) begin
            total++;
            bad++;
            $display("FAIL rx_ready_wait: got 0 want 1");
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [7:0] flip);
        logic [7:0] c;
        logic [7:0] b;
        c = n[7:0] ^ n[15:8];
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = payload[w][8*k +: 8];
                c = c ^ b;
                if (k == 3) sb.push_back('{addr: w[AW-1:0], data: payload[w]});
                send_byte(b);
            end
        end
        send_byte(c ^ flip);
    endtask

    task automatic check_reset_values(input string tag);
        expect_eq({tag, "_rx_ready"},   32'(rx_ready),     32'd0);
        expect_eq({tag, "_imem_we"},    32'(imem_we),      32'd0);
        expect_eq({tag, "_imem_addr"},  32'(imem_addr),    32'd0);
        expect_eq({tag, "_imem_wdata"}, imem_wdata,        32'd0);
        expect_eq({tag, "_core_reset"}, 32'(core_reset),   32'd1);
        expect_eq({tag, "_busy"},       32'(busy),         32'd0);
        expect_eq({tag, "_done"},       32'(done),         32'd0);
        expect_eq({tag, "_error"},      32'(error),        32'd0);
        expect_eq({tag, "_words"},      32'(words_loaded), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int n;
        vecs[0] = '{1, 32'h0000_0013, 32'h0, 32'h0, 8'h00, 1'b1};
        vecs[1] = '{3, 32'h0050_0093, 32'h0010_0113, 32'h0020_81B3, 8'h00, 1'b1};
        vecs[2] = '{1, 32'h0000_0013, 32'h0, 32'h0, 8'h01, 1'b0};
        vecs[3] = '{0, 32'h0, 32'h0, 32'h0, 8'h00, 1'b1};
        vecs[4] = '{2, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 8'h80, 1'b0};

        reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        reset = 1'b1;
        @(posedge clk); #1;
        expect_eq("idle_no_accept", 32'(rx_ready), 32'd0);

        for (int i = 0; i < 5; i++) begin
            payload[0] = vecs[i].w0;
            payload[1] = vecs[i].w1;
            payload[2] = vecs[i].w2;
            w0 = nwrites;
            pulse_start();
            expect_eq("start_busy",  32'(busy),         32'd1);
            expect_eq("start_ready", 32'(rx_ready),     32'd1);
            expect_eq("start_error", 32'(error),        32'd0);
            expect_eq("start_done",  32'(done),         32'd0);
            expect_eq("start_words", 32'(words_loaded), 32'd0);
            expect_eq("start_core",  32'(core_reset),   32'd1);
            send_frame(vecs[i].n, vecs[i].flip);
            @(negedge clk);
            #1;
            expect_eq("vec_done",   32'(done),         32'(vecs[i].exp_done));
            expect_eq("vec_error",  32'(error),        32'(!vecs[i].exp_done));
            expect_eq("vec_core",   32'(core_reset),   32'(!vecs[i].exp_done));
            expect_eq("vec_busy",   32'(busy),         32'd0);
            expect_eq("vec_words",  32'(words_loaded), 32'(vecs[i].n));
            expect_eq("vec_writes", 32'(nwrites - w0), 32'(vecs[i].n));
            @(posedge clk); #1;
        end

        // Largest legal image: 256 words fill the whole memory without wrapping.
        for (int w = 0; w < 256; w++) payload[w] = $urandom;
        w0 = nwrites;
        pulse_start();
        send_frame(256, 8'h00);
        @(negedge clk); #1;
        expect_eq("max_done",   32'(done),         32'd1);
        expect_eq("max_words",  32'(words_loaded), 32'd256);
        expect_eq("max_writes", 32'(nwrites - w0), 32'd256);
        @(posedge clk); #1;

        // Oversized length is rejected right after the high byte.
        w0 = nwrites;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        expect_eq("big_error", 32'(error),    32'd1);
        expect_eq("big_ready", 32'(rx_ready), 32'd0);
        expect_eq("big_core",  32'(core_reset), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        expect_eq("big_writes", 32'(nwrites - w0), 32'd0);

        // Stall mid-word until timeout; a start pulse while busy must not restart.
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        n = 0;
        while (!error && n < 200) begin
            @(posedge clk); #1;
            n++;
            start = (n == 10);
            if (n == 11) begin
                expect_eq("busy_start_ignored", 32'(busy), 32'd1);
            end
        end
        start = 1'b0;
        expect_eq("timeout_cycles", 32'(n),     32'(TO));
        expect_eq("timeout_error",  32'(error), 32'd1);
        expect_eq("timeout_busy",   32'(busy),  32'd0);

        // Async reset in the middle of a load.
        payload[0] = 32'h0000_0013;
        w0 = nwrites;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        expect_eq("abort_writes", 32'(nwrites - w0), 32'd0);
        expect_eq("sb_empty",     32'(sb.size()),    32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
